// File: rtl/popcount_frame_seq_pkg.sv
// rtl/popcount_frame_seq_pkg.sv - shared state encoding and width helpers for popcount_frame_seq
package popcount_frame_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    // Bits needed to hold values 0..max_val inclusive.
    function automatic int count_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/popcount_frame_seq_bvs.sv
// rtl/popcount_frame_seq_bvs.sv - combinational bit-vector sum (popcount) of one chunk
module bit_vector_sum #(
    parameter int DATA_W = 8,
    parameter int SUM_W  = $clog2(DATA_W + 1)
) (
    input  logic [DATA_W-1:0] data,
    output logic [SUM_W-1:0]  sum
);

    always_comb begin
        sum = '0;
        for (int i = 0; i < DATA_W; i++) begin
            sum = sum + SUM_W'(data[i]);
        end
    end

endmodule

// File: rtl/popcount_frame_seq.sv
// rtl/popcount_frame_seq.sv - per-frame set-bit counter sharing one chunk-wide popcount
module popcount_frame_seq
    import popcount_frame_seq_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int CHUNK_W   = 8,
    parameter int MAX_WORDS = 16,
    parameter int NCHUNK    = DATA_W / CHUNK_W,
    parameter int SUM_W     = count_width(DATA_W * MAX_WORDS),
    parameter int WCNT_W    = count_width(MAX_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SUM_W-1:0]  out_sum,
    output logic [WCNT_W-1:0] out_words,
    output logic              out_ovf
);

    localparam int KIDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int PCW    = count_width(CHUNK_W);

    seq_state_t          state, state_nxt;
    logic [DATA_W-1:0]   word_reg;
    logic                last_flag;
    logic [WCNT_W-1:0]   wcnt;
    logic [KIDX_W-1:0]   kidx;
    logic [SUM_W-1:0]    acc;
    logic                ovf;

    logic [CHUNK_W-1:0]  chunk;
    logic [PCW-1:0]      chunk_sum;
    logic                last_chunk;
    logic                at_max;
    logic                close_frame;

    always_comb begin
        chunk = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (kidx == KIDX_W'(i)) begin
                chunk = word_reg[i*CHUNK_W +: CHUNK_W];
            end
        end
    end

    bit_vector_sum #(
        .DATA_W (CHUNK_W),
        .SUM_W  (PCW)
    ) u_bvs (
        .data (chunk),
        .sum  (chunk_sum)
    );

    assign last_chunk  = (kidx == KIDX_W'(NCHUNK - 1));
    assign at_max      = (wcnt == WCNT_W'(MAX_WORDS));
    assign close_frame = last_flag || at_max;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid) state_nxt = ST_SCAN;
            ST_SCAN: if (last_chunk) state_nxt = close_frame ? ST_DONE : ST_IDLE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            word_reg  <= '0;
            last_flag <= 1'b0;
            wcnt      <= '0;
            kidx      <= '0;
            acc       <= '0;
            ovf       <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        word_reg  <= in_data;
                        last_flag <= in_last;
                        wcnt      <= wcnt + WCNT_W'(1);
                        kidx      <= '0;
                    end
                end
                ST_SCAN: begin
                    acc  <= acc + SUM_W'(chunk_sum);
                    kidx <= kidx + KIDX_W'(1);
                    // Overflow is latched as the frame closes so out_ovf is a plain register.
                    if (last_chunk && close_frame) begin
                        ovf <= at_max && !last_flag;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        acc       <= '0;
                        wcnt      <= '0;
                        last_flag <= 1'b0;
                        ovf       <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign out_sum   = acc;
    assign out_words = wcnt;
    assign out_ovf   = ovf;

endmodule

// File: tb/tb_popcount_frame_seq.sv
// tb/tb_popcount_frame_seq.sv - directed self-checking bench for popcount_frame_seq
module tb_popcount_frame_seq;

    localparam int DATA_W    = 32;
    localparam int CHUNK_W   = 8;
    localparam int MAX_WORDS = 4;
    localparam int SUM_W     = 8;
    localparam int WCNT_W    = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [SUM_W-1:0]  out_sum;
    logic [WCNT_W-1:0] out_words;
    logic              out_ovf;

    int errors = 0;
    int checks = 0;

    popcount_frame_seq #(
        .DATA_W    (DATA_W),
        .CHUNK_W   (CHUNK_W),
        .MAX_WORDS (MAX_WORDS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_words (out_words),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accepting posedge.
    task automatic send_word(input logic [31:0] d, input logic l);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    // Non-final word: in_ready low for NCHUNK sampled cycles, then high.
    task automatic check_scan_gap(input string tag);
        for (int i = 0; i < 4; i++) begin
            check({tag, "_ready_low"}, 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic take_result(input string tag, input int exp_sum, input int exp_words,
                               input logic exp_ovf);
        int lat;
        wait_result(lat);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_sum"}, 32'(out_sum), 32'(exp_sum));
        check({tag, "_words"}, 32'(out_words), 32'(exp_words));
        check({tag, "_ovf"}, 32'(out_ovf), 32'(exp_ovf));
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_out_words", 32'(out_words), 32'd0);
        check("rst_out_ovf", 32'(out_ovf), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single full word: result after edge t+4
        send_word(32'hFFFF_FFFF, 1'b1);
        check("t1_ready_low", 32'(in_ready), 32'd0);
        wait_result(lat);
        check("t1_latency", 32'(lat), 32'd4);
        take_result("t1", 32, 1, 1'b0);

        // Three-word frame: 1 + 1 + 16
        send_word(32'h0000_0001, 1'b0);
        check_scan_gap("t2_w0");
        send_word(32'h8000_0000, 1'b0);
        check_scan_gap("t2_w1");
        send_word(32'h0F0F_0F0F, 1'b1);
        take_result("t2", 18, 3, 1'b0);

        // Result held under backpressure
        send_word(32'hA5A5_A5A5, 1'b1);
        wait_result(lat);
        for (int i = 0; i < 10; i++) begin
            check("t3_hold_valid", 32'(out_valid), 32'd1);
            check("t3_hold_sum", 32'(out_sum), 32'd16);
            check("t3_hold_words", 32'(out_words), 32'd1);
            check("t3_hold_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        take_result("t3", 16, 1, 1'b0);

        // Forced close at MAX_WORDS, then a fresh frame
        for (int i = 0; i < MAX_WORDS; i++) send_word(32'h0000_00FF, 1'b0);
        take_result("t4_ovf", 32, 4, 1'b1);
        send_word(32'h0000_0003, 1'b1);
        take_result("t4_next", 2, 1, 1'b0);

        // Reset during SCAN of the second word discards the partial frame
        send_word(32'hFFFF_FFFF, 1'b0);
        send_word(32'hFFFF_FFFF, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("t5_ready", 32'(in_ready), 32'd1);
        check("t5_valid", 32'(out_valid), 32'd0);
        check("t5_sum", 32'(out_sum), 32'd0);
        check("t5_words", 32'(out_words), 32'd0);
        send_word(32'h0000_0001, 1'b1);
        take_result("t5", 1, 1, 1'b0);

        // Two all-zero words
        send_word(32'h0000_0000, 1'b0);
        send_word(32'h0000_0000, 1'b1);
        take_result("t6", 0, 2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
